// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: length-prefixed big-endian byte stream,
// word writes at consecutive addresses, trailing 8-bit checksum, CPU hold until clean load.
module imem_loader #(
  parameter int unsigned MAX_WORDS = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned TIMEOUT   = 1000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_start_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        byte_ready_o,
  output logic        wr_en_o,
  output logic [31:0] wr_addr_o,
  output logic [31:0] wr_data_o,
  output logic        cpu_hold_o,
  output logic        done_o,
  output logic        err_o,
  output logic [15:0] words_loaded_o
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic              byte_ready_q, wr_en_q, cpu_hold_q, done_q, err_q;
  logic [31:0]       wr_addr_q, wr_data_q, addr_q;
  logic [23:0]       asm_q;
  logic [7:0]        len_hi_q, csum_q;
  logic [15:0]       len_q, words_q;
  logic [1:0]        byte_cnt_q;
  logic [TMO_W-1:0]  tmo_q;

  logic        active, next_active, start, accept, tmo_hit, last_byte, last_word;
  logic [15:0] len_n;

  assign active      = state_q inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM};
  assign next_active = state_d inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM};
  assign start       = !active && load_start_i;
  assign accept      = byte_valid_i && byte_ready_q;
  assign tmo_hit     = active && !accept && (tmo_q == TMO_W'(TIMEOUT - 1));
  assign len_n       = {len_hi_q, byte_i};
  assign last_byte   = (byte_cnt_q == 2'd3);
  assign last_word   = ((words_q + 16'd1) == len_q);

  // Next-state decode; a timeout overrides any pending transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (load_start_i) state_d = S_LEN_HI;
      S_LEN_HI: if (accept) state_d = S_LEN_LO;
      S_LEN_LO: begin
        if (accept) begin
          if (32'(len_n) > MAX_WORDS) state_d = S_ERR;
          else if (len_n == 16'd0)    state_d = S_CSUM;
          else                        state_d = S_DATA;
        end
      end
      S_DATA: if (accept && last_byte && last_word) state_d = S_CSUM;
      S_CSUM: if (accept) state_d = (byte_i == csum_q) ? S_DONE : S_ERR;
      default: state_d = S_IDLE;
    endcase
    if (tmo_hit) state_d = S_ERR;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= BASE_ADDR;
      wr_data_q    <= 32'd0;
      cpu_hold_q   <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= BASE_ADDR;
      asm_q        <= 24'd0;
      len_hi_q     <= 8'd0;
      len_q        <= 16'd0;
      csum_q       <= 8'd0;
      words_q      <= 16'd0;
      byte_cnt_q   <= 2'd0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      wr_en_q      <= 1'b0;
      // Ready stays low for the first LEN_HI cycle after a start.
      byte_ready_q <= next_active && !start;
      done_q       <= (state_d == S_DONE);
      err_q        <= (state_d == S_ERR);
      cpu_hold_q   <= (state_d != S_DONE);
      if (start) begin
        addr_q     <= BASE_ADDR;
        csum_q     <= 8'd0;
        words_q    <= 16'd0;
        byte_cnt_q <= 2'd0;
        tmo_q      <= '0;
      end else if (active) begin
        tmo_q <= accept ? '0 : tmo_q + TMO_W'(1);
        if (accept) begin
          case (state_q)
            S_LEN_HI: len_hi_q <= byte_i;
            S_LEN_LO: len_q    <= len_n;
            S_DATA: begin
              asm_q      <= {asm_q[15:0], byte_i};
              csum_q     <= csum_q + byte_i;
              byte_cnt_q <= byte_cnt_q + 2'd1;
              if (last_byte) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= addr_q;
                wr_data_q <= {asm_q, byte_i};
                addr_q    <= addr_q + 32'd4;
                words_q   <= words_q + 16'd1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign byte_ready_o   = byte_ready_q;
  assign wr_en_o        = wr_en_q;
  assign wr_addr_o      = wr_addr_q;
  assign wr_data_o      = wr_data_q;
  assign cpu_hold_o     = cpu_hold_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign words_loaded_o = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized and directed bench for imem_loader against a stream-level reference model.
module tb_imem_loader;

  localparam int          TO    = 20;
  localparam int          MAXW  = 32;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  typedef logic [7:0] bq_t [$];
  typedef int         iq_t [$];

  logic        clk = 1'b0;
  logic        rst_i, load_start_i, byte_valid_i;
  logic [7:0]  byte_i;
  logic        byte_ready_o, wr_en_o, cpu_hold_o, done_o, err_o;
  logic [31:0] wr_addr_o, wr_data_o;
  logic [15:0] words_loaded_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] got_addr[$], got_data[$], exp_addr[$], exp_data[$];
  logic        exp_done, exp_err;

  imem_loader #(.MAX_WORDS(MAXW), .BASE_ADDR(BASE), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_i), .load_start_i(load_start_i),
    .byte_valid_i(byte_valid_i), .byte_i(byte_i), .byte_ready_o(byte_ready_o),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .cpu_hold_o(cpu_hold_o), .done_o(done_o), .err_o(err_o),
    .words_loaded_o(words_loaded_o)
  );

  always #5 clk = ~clk;

  // Capture every write strobe seen on the memory port.
  always @(negedge clk) begin
    if (wr_en_o) begin
      got_addr.push_back(wr_addr_o);
      got_data.push_back(wr_data_o);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Stream-level reference: what writes and outcome the byte list and gaps must produce.
  task automatic model(input bq_t b, input iq_t g);
    int n, sum;
    logic [31:0] w;
    exp_addr.delete(); exp_data.delete();
    exp_done = 1'b0; exp_err = 1'b0;
    n = 0; sum = 0; w = 32'd0;
    for (int i = 0; i < b.size(); i++) begin
      if (i > 0 && g[i] >= TO) begin exp_err = 1'b1; return; end
      if (i == 0) n = int'(b[0]) * 256;
      else if (i == 1) begin
        n = n + int'(b[1]);
        if (n > MAXW) begin exp_err = 1'b1; return; end
      end else if (i < 2 + 4 * n) begin
        sum = sum + int'(b[i]);
        w = {w[23:0], b[i]};
        if ((i - 2) % 4 == 3) begin
          exp_addr.push_back(BASE + 32'(4 * ((i - 2) / 4)));
          exp_data.push_back(w);
        end
      end else begin
        if (int'(b[i]) == sum % 256) exp_done = 1'b1;
        else exp_err = 1'b1;
        return;
      end
    end
  endtask

  task automatic drive(input bq_t b, input iq_t g, input int n_send, input int pulse_idx);
    int waited;
    for (int i = 0; i < n_send && i < b.size(); i++) begin
      for (int k = 0; k < g[i]; k++) begin byte_valid_i = 1'b0; @(negedge clk); end
      waited = 0;
      while (!byte_ready_o && waited < 8) begin
        byte_valid_i = 1'b0; @(negedge clk); waited++;
      end
      if (!byte_ready_o) break;
      byte_valid_i = 1'b1; byte_i = b[i]; load_start_i = (i == pulse_idx);
      @(negedge clk);
      load_start_i = 1'b0;
    end
    byte_valid_i = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); load_start_i = 1'b1;
    @(negedge clk); load_start_i = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".ready"}, 32'(byte_ready_o), 32'd0);
    check({tag, ".wr_en"}, 32'(wr_en_o), 32'd0);
    check({tag, ".wr_addr"}, wr_addr_o, BASE);
    check({tag, ".wr_data"}, wr_data_o, 32'd0);
    check({tag, ".hold"}, 32'(cpu_hold_o), 32'd1);
    check({tag, ".done"}, 32'(done_o), 32'd0);
    check({tag, ".err"}, 32'(err_o), 32'd0);
    check({tag, ".words"}, 32'(words_loaded_o), 32'd0);
  endtask

  task automatic run_load(input string tag, input bq_t b, input iq_t g, input int pulse_idx);
    int m;
    got_addr.delete(); got_data.delete();
    model(b, g);
    pulse_start();
    drive(b, g, b.size(), pulse_idx);
    repeat (3) @(negedge clk);
    check({tag, ".nwr"}, 32'(got_addr.size()), 32'(exp_addr.size()));
    m = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s.addr%0d", tag, i), got_addr[i], exp_addr[i]);
      check($sformatf("%s.data%0d", tag, i), got_data[i], exp_data[i]);
    end
    check({tag, ".done"}, 32'(done_o), 32'(exp_done));
    check({tag, ".err"}, 32'(err_o), 32'(exp_err));
    check({tag, ".hold"}, 32'(cpu_hold_o), 32'(!exp_done));
    check({tag, ".words"}, 32'(words_loaded_o), 32'(exp_addr.size()));
    check({tag, ".ready"}, 32'(byte_ready_o), 32'd0);
  endtask

  function automatic iq_t zero_gaps(input int n);
    iq_t g;
    for (int i = 0; i < n; i++) g.push_back(0);
    return g;
  endfunction

  initial begin
    bq_t s, s_bad, s_big, s_z, s_zb;
    iq_t g;
    rst_i = 1'b1; load_start_i = 1'b0; byte_valid_i = 1'b0; byte_i = 8'h00;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    check_reset_vals("reset");

    s     = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h26};
    s_bad = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h27};
    s_big = '{8'h00, 8'h21, 8'h11, 8'h22, 8'h33};
    s_z   = '{8'h00, 8'h00, 8'h00};
    s_zb  = '{8'h00, 8'h00, 8'h01};

    run_load("good", s, zero_gaps(s.size()), -1);
    check("good.fixed_data0", got_data.size() > 0 ? got_data[0] : 32'hdead_beef, 32'h2001_0005);
    run_load("badsum", s_bad, zero_gaps(s_bad.size()), -1);
    run_load("toolong", s_big, zero_gaps(s_big.size()), -1);
    run_load("n0", s_z, zero_gaps(s_z.size()), -1);
    run_load("n0bad", s_zb, zero_gaps(s_zb.size()), -1);

    g = zero_gaps(s.size()); g[4] = TO - 1;
    run_load("tmo_edge", s, g, -1);
    g[4] = TO;
    run_load("tmo_hit", s, g, -1);

    // Reset mid-word after six data bytes.
    got_addr.delete(); got_data.delete();
    pulse_start();
    drive(s, zero_gaps(s.size()), 8, -1);
    @(negedge clk); rst_i = 1'b1;
    @(negedge clk); rst_i = 1'b0;
    check_reset_vals("midrst");
    repeat (5) @(negedge clk);
    check("midrst.nwr", 32'(got_addr.size()), 32'd1);
    run_load("after_rst", s, zero_gaps(s.size()), -1);
    run_load("restart_ign", s, zero_gaps(s.size()), 5);

    for (int t = 0; t < 40; t++) begin
      bq_t b;
      iq_t gg;
      int n, r, sum;
      r = int'($urandom_range(0, 19));
      if (r == 0) n = MAXW;
      else if (r == 1) n = int'($urandom_range(33, 300));
      else if (r == 2) n = 0;
      else n = int'($urandom_range(1, 8));
      b.push_back(8'(n >> 8)); b.push_back(8'(n));
      if (n <= MAXW) begin
        sum = 0;
        for (int i = 0; i < 4 * n; i++) begin
          b.push_back(8'($urandom));
          sum = sum + int'(b[b.size() - 1]);
        end
        if ($urandom_range(0, 3) == 0) sum = sum + int'($urandom_range(1, 255));
        b.push_back(8'(sum));
      end else begin
        b.push_back(8'($urandom)); b.push_back(8'($urandom));
      end
      gg.push_back(0);
      for (int i = 1; i < b.size(); i++) begin
        r = int'($urandom_range(0, 199));
        if (r == 0) gg.push_back(TO);
        else if (r == 1) gg.push_back(TO - 1);
        else if (r < 20) gg.push_back(int'($urandom_range(1, 5)));
        else gg.push_back(0);
      end
      run_load($sformatf("rnd%0d", t), b, gg, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
